// File: rtl/bcd_pkg.sv
// Shared types and helpers for the digit-serial BCD adder/subtractor.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Nines' complement of one decimal digit; ten's complement is this plus an
  // initial carry of 1.
  function automatic bcd_digit_t nines_comp(input bcd_digit_t d);
    return BCD_MAX - d;
  endfunction

endpackage

// File: rtl/bcd_digit_adder.sv
// Single decimal digit adder: binary add of two BCD digits plus carry, then
// the >9 correction back into the 0..9 range.
module bcd_digit_adder
  import bcd_pkg::*;
(
  input  bcd_digit_t a,
  input  bcd_digit_t b,
  input  logic       cin,
  output bcd_digit_t s,
  output logic       cout
);

  logic [4:0] raw_sum;

  // Binary sum, then subtract ten when the digit overflows the decimal range.
  always_comb begin
    raw_sum = {1'b0, a} + {1'b0, b} + {4'b0, cin};
    if (raw_sum > {1'b0, BCD_MAX}) begin
      s    = 4'(raw_sum - 5'd10);
      cout = 1'b1;
    end else begin
      s    = raw_sum[3:0];
      cout = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_addsub.sv
// Digit-serial packed-BCD adder/subtractor. One digit per cycle, LSD first,
// through a single bcd_digit_adder. Subtraction adds the nines' complement
// of b with an initial carry of 1.
module bcd_serial_addsub
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  sub,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic                  ready,
  output logic                  done,
  output logic [4*DIGITS-1:0]   result,
  output logic                  cout,
  output logic                  err
);

  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     result_q, result_d;
  logic             cout_q, cout_d;
  logic             err_q, err_d;

  logic             in_bad;
  logic [W-1:0]     b_in;
  bcd_digit_t       dig_a, dig_b, dig_s;
  logic             dig_cout;

  // Flag any operand digit outside 0..9 at the inputs.
  always_comb begin
    in_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (a[4*i +: 4] > BCD_MAX || b[4*i +: 4] > BCD_MAX) in_bad = 1'b1;
    end
  end

  // Operand b as it is latched: nines' complement per digit when subtracting.
  always_comb begin
    b_in = b;
    for (int i = 0; i < DIGITS; i++) begin
      if (sub) b_in[4*i +: 4] = nines_comp(b[4*i +: 4]);
    end
  end

  // Current digit pair presented to the digit adder.
  always_comb begin
    dig_a = a_q[4*idx_q +: 4];
    dig_b = b_q[4*idx_q +: 4];
  end

  bcd_digit_adder u_digit_adder (
    .a    (dig_a),
    .b    (dig_b),
    .cin  (carry_q),
    .s    (dig_s),
    .cout (dig_cout)
  );

  // Next-state, datapath updates and decoded outputs.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    cout_d   = cout_q;
    err_d    = err_q;
    ready    = 1'b0;
    done     = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        ready = 1'b1;
        done  = (state_q == DONE);
        if (start) begin
          a_d      = a;
          b_d      = b_in;
          carry_d  = sub;
          idx_d    = '0;
          result_d = '0;
          cout_d   = 1'b0;
          err_d    = in_bad;
          state_d  = in_bad ? DONE : RUN;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        result_d[4*idx_q +: 4] = dig_s;
        carry_d = dig_cout;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          cout_d  = dig_cout;
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      err_q    <= err_d;
    end
  end

  // Operand working registers: always overwritten at accept before use, so
  // they carry no reset.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign result = result_q;
  assign cout   = cout_q;
  assign err    = err_q;

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Self-checking bench for bcd_serial_addsub (DIGITS=4), scoreboard based.
module tb_bcd_serial_addsub;

  localparam int D = 4;
  localparam int W = 4 * D;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         err;

  typedef struct packed {
    logic [W-1:0] result;
    logic         cout;
    logic         err;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  bcd_serial_addsub #(.DIGITS(D)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .sub    (sub),
    .a      (a),
    .b      (b),
    .ready  (ready),
    .done   (done),
    .result (result),
    .cout   (cout),
    .err    (err)
  );

  always #5 clk = ~clk;

  function automatic int bcd2int(input logic [W-1:0] v);
    int r = 0;
    for (int i = D - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] r = '0;
    int t = v;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Reference model in plain decimal arithmetic.
  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic sv);
    exp_t e;
    int   p = 1;
    int   x;
    logic bad = 1'b0;
    for (int i = 0; i < D; i++) begin
      p = p * 10;
      if (av[4*i +: 4] > 4'd9 || bv[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    if (bad) begin
      e.result = '0; e.cout = 1'b0; e.err = 1'b1;
    end else if (!sv) begin
      x = bcd2int(av) + bcd2int(bv);
      e.cout = (x >= p); e.result = int2bcd(x % p); e.err = 1'b0;
    end else begin
      x = bcd2int(av) - bcd2int(bv);
      e.cout = (x >= 0); e.result = int2bcd(x >= 0 ? x : x + p); e.err = 1'b0;
    end
    return e;
  endfunction

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] r;
    for (int i = 0; i < D; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operation for a single edge and record its expectation.
  task automatic accept(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv);
    a = av; b = bv; sub = sv; start = 1'b1;
    tick();
    start = 1'b0;
    sb.push_back(model(av, bv, sv));
  endtask

  // Wait for done (scrambling operands meanwhile), check latency and result.
  task automatic finish_op(input string name, input int exp_lat);
    int   lat = 0;
    exp_t e;
    while (!done && lat < 40) begin
      n_cmp++;
      if (ready !== 1'b0) begin
        n_bad++; $display("FAIL %s ready_in_run: got %b want 0 (cycle %0d)", name, ready, lat);
      end
      a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
      tick();
      lat++;
    end
    n_cmp++;
    if (lat !== exp_lat) begin
      n_bad++; $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
    end
    n_cmp++;
    if (ready !== 1'b1) begin
      n_bad++; $display("FAIL %s ready_at_done: got %b want 1", name, ready);
    end
    if (sb.size() == 0) begin
      n_cmp++; n_bad++; $display("FAIL %s scoreboard: got empty want entry", name);
    end else begin
      e = sb.pop_front();
      n_cmp++;
      if ({result, cout, err} !== {e.result, e.cout, e.err}) begin
        n_bad++;
        $display("FAIL %s result: got %h/c%b/e%b want %h/c%b/e%b", name,
                 result, cout, err, e.result, e.cout, e.err);
      end
    end
  endtask

  task automatic check_idle_outputs(input string name);
    n_cmp++;
    if ({ready, done, result, cout, err} !== {1'b1, 1'b0, {W{1'b0}}, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL %s: got rdy%b done%b %h c%b e%b want rdy1 done0 0000 c0 e0", name,
               ready, done, result, cout, err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    tick(); tick();
    rst = 1'b0;
    check_idle_outputs("reset");
  endtask

  task automatic test_add();
    accept(16'h1234, 16'h5678, 1'b0);
    finish_op("add_1234_5678", D);
    tick();
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++; $display("FAIL done_pulse: got %b want 0", done);
    end
    accept(16'h9999, 16'h0001, 1'b0);
    finish_op("add_overflow", D);
    accept(16'h0000, 16'h0000, 1'b0);
    finish_op("add_zero", D);
  endtask

  task automatic test_sub();
    accept(16'h5000, 16'h1234, 1'b1);
    finish_op("sub_pos", D);
    accept(16'h1234, 16'h5000, 1'b1);
    finish_op("sub_neg", D);
    accept(16'h4321, 16'h4321, 1'b1);
    finish_op("sub_equal", D);
  endtask

  task automatic test_invalid();
    accept(16'h12A4, 16'h0001, 1'b0);
    finish_op("invalid_a", 0);
    // Valid start while still in the DONE cycle of the error result.
    accept(16'h0042, 16'h0058, 1'b0);
    finish_op("start_in_done", D);
    accept(16'h0001, 16'hF000, 1'b1);
    finish_op("invalid_b", 0);
    tick();
  endtask

  // start held high with fresh operands every cycle: accepts only when ready.
  task automatic test_back_to_back();
    int   accepts[$];
    int   n_done = 0;
    logic was_ready;
    exp_t e;
    start = 1'b1;
    for (int i = 0; i < 3 * (D + 1); i++) begin
      a = rand_bcd(); b = rand_bcd(); sub = 1'($urandom);
      was_ready = ready;
      if (was_ready) sb.push_back(model(a, b, sub));
      tick();
      if (was_ready) accepts.push_back(i);
      if (done) begin
        n_done++;
        e = sb.pop_front();
        n_cmp++;
        if ({result, cout, err} !== {e.result, e.cout, e.err}) begin
          n_bad++;
          $display("FAIL b2b_result%0d: got %h/c%b/e%b want %h/c%b/e%b", n_done,
                   result, cout, err, e.result, e.cout, e.err);
        end
      end
    end
    start = 1'b0;
    n_cmp++;
    if (accepts.size() !== 3 || n_done !== 3) begin
      n_bad++; $display("FAIL b2b_counts: got %0d accepts %0d dones want 3 3",
                        accepts.size(), n_done);
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (accepts[k] !== k * (D + 1)) begin
          n_bad++; $display("FAIL b2b_accept_time%0d: got %0d want %0d", k, accepts[k], k * (D + 1));
        end
      end
    end
    tick();
  endtask

  task automatic test_mid_reset();
    a = 16'h8765; b = 16'h4321; sub = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_outputs("mid_run_reset");
    accept(16'h0999, 16'h0001, 1'b0);
    finish_op("after_reset", D);
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_invalid();
    test_back_to_back();
    test_mid_reset();
    n_cmp++;
    if (sb.size() !== 0) begin
      n_bad++; $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_serial_addsub.md
Name: bcd_serial_addsub

Overview:
Digit-serial BCD adder/subtractor for multi-digit packed-BCD operands. It sequences one 4-bit digit per cycle, least-significant digit first, through a single decimal digit adder. The block sits directly upstream of the 4-bit digit adder stage: it feeds operand digits and carry in, and collects sum digits and carry out. Subtraction uses ten's complement: the nines' complement of b, with initial carry 1.

Parameters:
DIGITS, 4, number of BCD digits per operand (at least 1); operand width is 4*DIGITS.

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request a new operation; sampled only when ready
sub  input  1  0 = a+b, 1 = a-b; sampled with start
a  input  4*DIGITS  packed BCD operand, digit 0 in bits [3:0]
b  input  4*DIGITS  packed BCD operand, same packing
ready  output  1  high in IDLE and DONE, when a start will be accepted
done  output  1  one-cycle pulse when result, cout and err are valid
result  output  4*DIGITS  packed BCD result; held until the next accepted start
cout  output  1  add: decimal carry out; sub: 1 = no borrow (a>=b), 0 = negative (result is ten's complement)
err  output  1  1 = some input digit was greater than 9; held with result

Behaviour:
- Reset: synchronous on rst=1 at a clk edge, from any state including mid-run. Effects: state=IDLE, ready=1, done=0, result=0, cout=0, err=0, digit index=0, carry=0.
- States:
  - IDLE: ready=1. start=1 goes to RUN, or to DONE if any digit is invalid.
  - RUN: ready=0. Processes one digit per cycle.
  - DONE: ready=1, done=1 for exactly one cycle. start=1 goes to RUN (or DONE); otherwise goes to IDLE.
- Accept, at cycle T:
  - Latch a, sub and b into working registers.
  - When sub=1, the b register holds the per-digit nines' complement (9-b_i).
  - carry = sub; index = 0; err cleared.
- Validity check at accept: if any a_i or b_i is greater than 9, skip RUN. The next state is DONE, so done is high at T+1 with err=1, result=0 and cout=0.
- Each RUN cycle, for digit i:
  - Form s = a_i + b'_i + carry, 5-bit.
  - If s>9: digit = s-10, carry=1; else digit = s, carry=0.
  - Write the digit into result[4i+3:4i]; index increments.
  - After digit DIGITS-1, the next state is DONE and cout = final carry.
- Latency: a valid start accepted at T gives RUN cycles T+1..T+DIGITS and done=1 at T+DIGITS+1. Throughput is one operation per DIGITS+1 cycles when start is held high.
- Ignored inputs:
  - start while in RUN is ignored. No queuing, no error.
  - a, b and sub changing during RUN have no effect.
- result is updated digit-by-digit during RUN and is valid only when done=1. After DONE it is held until the next accepted start.
- Wrap-around: an add overflow (e.g. 9999+0001) gives result 0000 with cout=1. A sub with a<b gives the ten's complement with cout=0. Magnitude conversion is not performed in this block.
- No combinational path from inputs to outputs; all outputs are registered.

Decomposition:
- Package bcd_pkg:
  - typedef bcd_digit_t (logic [3:0])
  - constant BCD_MAX=9
  - enum state_t {IDLE, RUN, DONE}
  - function nines_comp(bcd_digit_t)
- Sub-module bcd_digit_adder: combinational. Inputs a, b (bcd_digit_t) and cin; outputs s (bcd_digit_t) and cout; performs the >9 correction.
- bcd_serial_addsub holds only the FSM, the index counter, the carry flop and the shift/write logic.

Test Plan:
1. DIGITS=4, a=0x1234, b=0x5678, sub=0, start at T -> done at T+5; result=0x6912, cout=0, err=0.
2. a=0x9999, b=0x0001, sub=0 -> result=0x0000, cout=1; ready low during T+1..T+4.
3. a=0x5000, b=0x1234, sub=1 -> result=0x3766, cout=1. Then a=0x1234, b=0x5000, sub=1 -> result=0x6234, cout=0.
4. a=0x12A4, b=0x0001, start at T -> done at T+1, err=1, result=0, cout=0. A valid start in the DONE cycle is accepted and runs normally.
5. start held high continuously with changing a/b -> ops accepted only at T, T+5, T+10; mid-run start and operand changes ignored; each result matches the operands latched at accept.
6. rst=1 at T+2 of a run -> next cycle: ready=1, done=0, result=0, cout=0, err=0. A following operation 0x0999+0x0001 gives 0x1000, cout=0.
